// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the E stage.
// Operands are evaluated at accept and the result is held in a pending
// register. Busy then runs a fixed countdown so stall timing is exact.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic        MoveWrite,
    input  logic        Cancel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    // Result waiting for its latency to expire; wr=0 means leave HI/LO alone.
    typedef struct packed {
        logic [2:0]  op;
        logic        wr;
        logic [31:0] hi;
        logic [31:0] lo;
    } pend_t;

    state_e        state, state_nxt;
    logic [CW-1:0] cnt;
    pend_t         pend, res;

    logic          accept, move, done;
    logic          is_div, is_signed;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   a_mag, b_mag, dvd, dvs, uq, ur, q_fix, r_fix;

    // Start always wins over MoveWrite; Cancel drops any new request.
    assign accept = Start && !Busy && !Cancel && !MDOp[2];
    assign move   = MoveWrite && !Start && !Busy && !Cancel
                    && (MDOp == OP_MTHI || MDOp == OP_MTLO);
    assign done   = (state == S_BUSY) && (cnt == CW'(1));
    assign Busy   = (state == S_BUSY);

    assign is_div    = MDOp[1];
    assign is_signed = !MDOp[0];

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'b0, A} * {32'b0, B};

    // Signed divide runs on magnitudes through the one unsigned divider;
    // the sign fix-up also gives 0x80000000 / -1 = 0x80000000 rem 0.
    always_comb begin
        a_mag = A[31] ? (~A + 32'd1) : A;
        b_mag = B[31] ? (~B + 32'd1) : B;
        dvd   = (is_signed) ? a_mag : A;
        dvs   = (is_signed) ? b_mag : B;
        if (dvs == 32'd0) dvs = 32'd1;
        uq    = dvd / dvs;
        ur    = dvd % dvs;
        q_fix = uq;
        r_fix = ur;
        if (is_signed) begin
            if (A[31] ^ B[31]) q_fix = ~uq + 32'd1;
            if (A[31])         r_fix = ~ur + 32'd1;
        end
    end

    // Select the result for the requested operation.
    always_comb begin
        res    = '0;
        res.op = MDOp;
        res.wr = 1'b1;
        case (MDOp)
            OP_MULT:  {res.hi, res.lo} = prod_s;
            OP_MULTU: {res.hi, res.lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                res.hi = r_fix;
                res.lo = q_fix;
                res.wr = (B != 32'd0);
            end
            default:  res.wr = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: idle until accepted, busy until the countdown reaches 1.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_BUSY;
            S_BUSY:  if (done)   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latency countdown and pending result capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            pend <= '0;
        end else if (accept) begin
            cnt  <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            pend <= res;
        end else if (done) begin
            cnt  <= '0;
        end else if (Busy) begin
            cnt  <= cnt - CW'(1);
        end
    end

    // Architectural HI/LO: written on completion or by MTHI/MTLO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI <= '0;
            LO <= '0;
        end else if (done) begin
            if (pend.wr) begin
                HI <= pend.hi;
                LO <= pend.lo;
            end
        end else if (move) begin
            if (MDOp == OP_MTHI) HI <= A;
            else                 LO <= A;
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle HI/LO multiply/divide unit in the E stage, directly downstream of the instruction controller.
- Consumes the controller's `Start` pulse (MULT/MULTU/DIV/DIVU), the MTHI/MTLO writes and the E-stage register operands.
- Exposes `Busy`, `HI` and `LO` to the hazard unit and to the MFHI/MFLO result mux.
- Emulates fixed latencies, so stall behaviour is cycle-exact and deterministic.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for MULT/MULTU (>=1).
- DIV_CYCLES, 10, cycles Busy stays high for DIV/DIVU (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Start  input  1  launch MULT/MULTU/DIV/DIVU this cycle (from the controller, E stage).
- MDOp  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved.
- MoveWrite  input  1  perform MTHI/MTLO this cycle (MDOp 100/101).
- Cancel  input  1  exception/interrupt flush of the E-stage instruction.
- A  input  32  rs operand (dividend / multiplicand / MT source).
- B  input  32  rt operand (divisor / multiplier).
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- Busy  output  1  operation in flight.

Behaviour:
- Reset (reset=0, asynchronous):
  - HI=0, LO=0, Busy=0, countdown=0.
  - Latched operands and result registers cleared.
  - Any in-flight operation is discarded.
- Accept condition: at a rising edge with Start=1, Busy=0, Cancel=0 and MDOp in {000..011}:
  - Latch MDOp and the result computed from A and B into internal pending registers.
  - Load countdown with MULT_CYCLES or DIV_CYCLES.
  - Set Busy=1.
- Completion:
  - Each following edge decrements countdown.
  - At the edge where countdown==1: HI/LO <= pending result, Busy <= 0, countdown <= 0.
  - Busy is therefore high for exactly N cycles; new HI/LO are visible in the first cycle Busy=0.
- MULT: {HI,LO} = signed 64-bit product of A and B.
- MULTU: {HI,LO} = unsigned 64-bit product of A and B.
- DIV (signed):
  - LO = quotient truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient to LO, unsigned remainder to HI.
- Divide by zero (B=0): accepted, Busy runs the full DIV_CYCLES, HI/LO left unchanged at completion.
- MTHI/MTLO: at an edge with MoveWrite=1, Busy=0, Cancel=0:
  - HI <= A (MDOp=100) or LO <= A (MDOp=101).
  - Takes effect immediately, no Busy.
- Start or MoveWrite while Busy=1 is ignored. The hazard unit stalls these instructions, and the bench flags this as a protocol error.
- Start and MoveWrite together are illegal. If it happens, Start wins.
- Cancel=1 suppresses any Start/MoveWrite in the same cycle.
- Cancel never aborts an operation already accepted; its instruction has committed.
- Reserved MDOp values with Start or MoveWrite are no-ops.
- HI/LO change only at reset, at completion, or on an MT write.
- Hazard contract (consumer side): the D stage stalls MFHI/MFLO/MTHI/MTLO/MULT/DIV while (E.Start | Busy).

Test Plan:
- MULT with A=0xFFFFFFFE (-2), B=3, Start for 1 cycle → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV with A=-7 (0xFFFFFFF9), B=2 → Busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Same operands with DIVU → LO=0x7FFFFFFC, HI=1.
- Divide by zero with HI=0x11, LO=0x22 preloaded via MTHI/MTLO; then DIV A=5, B=0 → Busy 10 cycles; HI=0x11 and LO=0x22 unchanged.
- Start=1 with Cancel=1 → Busy stays 0, HI/LO unchanged.
- Cancel pulsed in cycle 3 of a MULT → the MULT still completes normally.
- Drive reset=0 asynchronously (mid-clock) in cycle 4 of a DIV → HI=LO=0 and Busy=0 immediately. After release, a new MULT 6×7 gives LO=42 after 5 cycles.
